// File: rtl/pos_if.sv
// Screen position bundle (top-left corner of a drawn object).
interface pos_if;
    logic [10:0] x;
    logic [10:0] y;

    modport master (output x, y);
    modport slave  (input  x, y);
endinterface

// File: rtl/vga_if.sv
// VGA pixel stream bundle: raster counters, sync/blank strobes and 12-bit colour.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// Overlays one ROM-backed rectangular sprite on the VGA stream, with colour-key
// transparency, horizontal mirroring and a frame-counted blink effect.
module draw_sprite #(
    parameter int          SPRITE_W     = 64,
    parameter int          SPRITE_H     = 64,
    parameter int          ADDR_W       = 20,
    parameter int          ROM_LAT      = 1,
    parameter logic [11:0] TRANSP       = 12'hFFF,
    parameter int          BLINK_FRAMES = 60,
    parameter int          BLINK_LOG2   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       data,
    pos_if.slave              pin,
    input  logic              enable,
    input  logic              mirror,
    input  logic              blink_start,
    vga_if.slave              in,
    output logic [ADDR_W-1:0] address,
    vga_if.master             out
);

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        vblnk;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t v;
        logic hit;
    } px_t;

    logic [10:0]       x_l_q, x_l_d, y_l_q, y_l_d;
    logic              en_l_q, en_l_d, mir_l_q, mir_l_d;
    logic              vis_q, vis_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    px_t               pipe_q [ROM_LAT+1];
    px_t               pipe_d [ROM_LAT+1];
    vga_t              out_q, out_d;

    logic              frame_start;
    logic              hit;
    logic [11:0]       hc_ext, vc_ext, x_end, y_end;
    logic [10:0]       dx, col, row;
    logic [ADDR_W-1:0] lin;
    px_t               stage0, tail;

    assign frame_start = (in.vcount == 11'd0) && (in.hcount == 11'd0);

    // Frame-start latching and blink countdown; a reload beats a decrement.
    always_comb begin
        x_l_d   = x_l_q;
        y_l_d   = y_l_q;
        en_l_d  = en_l_q;
        mir_l_d = mir_l_q;
        cnt_d   = cnt_q;
        vis_d   = vis_q;
        if (frame_start) begin
            x_l_d   = pin.x;
            y_l_d   = pin.y;
            en_l_d  = enable;
            mir_l_d = mirror;
            if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        end
        if (blink_start) cnt_d = 8'(BLINK_FRAMES);
        if (frame_start) vis_d = (cnt_d == 8'd0) || !cnt_d[BLINK_LOG2];
    end

    // 12-bit compares so a sprite hanging past 2047 is clipped rather than wrapped.
    always_comb begin
        hc_ext = {1'b0, in.hcount};
        vc_ext = {1'b0, in.vcount};
        x_end  = {1'b0, x_l_q} + 12'(SPRITE_W);
        y_end  = {1'b0, y_l_q} + 12'(SPRITE_H);
        hit    = en_l_q && vis_q &&
                 (hc_ext >= {1'b0, x_l_q}) && (hc_ext < x_end) &&
                 (vc_ext >= {1'b0, y_l_q}) && (vc_ext < y_end);
        dx     = in.hcount - x_l_q;
        col    = mir_l_q ? (11'(SPRITE_W - 1) - dx) : dx;
        row    = in.vcount - y_l_q;
        lin    = ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
        address_d = hit ? lin : address_q;
    end

    always_comb begin
        stage0.v.vcount = in.vcount;
        stage0.v.hcount = in.hcount;
        stage0.v.vsync  = in.vsync;
        stage0.v.vblnk  = in.vblnk;
        stage0.v.hsync  = in.hsync;
        stage0.v.hblnk  = in.hblnk;
        stage0.v.rgb    = in.rgb;
        stage0.hit      = hit;
        pipe_d[0]       = stage0;
        for (int i = 1; i <= ROM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    // The tail stage lines up with the ROM word fetched for the same pixel.
    always_comb begin
        tail  = pipe_q[ROM_LAT];
        out_d = tail.v;
        if (tail.hit && (data != TRANSP)) out_d.rgb = data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_l_q     <= '0;
            y_l_q     <= '0;
            en_l_q    <= 1'b0;
            mir_l_q   <= 1'b0;
            cnt_q     <= '0;
            vis_q     <= 1'b1;
            address_q <= '0;
            out_q     <= '0;
            for (int i = 0; i <= ROM_LAT; i++) pipe_q[i] <= '0;
        end else begin
            x_l_q     <= x_l_d;
            y_l_q     <= y_l_d;
            en_l_q    <= en_l_d;
            mir_l_q   <= mir_l_d;
            cnt_q     <= cnt_d;
            vis_q     <= vis_d;
            address_q <= address_d;
            out_q     <= out_d;
            for (int i = 0; i <= ROM_LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign address    = address_q;
    assign out.vcount = out_q.vcount;
    assign out.hcount = out_q.hcount;
    assign out.vsync  = out_q.vsync;
    assign out.vblnk  = out_q.vblnk;
    assign out.hsync  = out_q.hsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: two instances (different size/latency/key/blink) against a
// per-pixel reference model, plus directed pixel checks on the small instance.
module tb_draw_sprite;
    localparam int H_TOT = 48, H_VIS = 40, V_TOT = 16, V_VIS = 13;

    logic        clk, rst, enable, mirror, blink_start;
    logic [11:0] data_a, data_b;
    logic [2:0]  addr_a;
    logic [3:0]  addr_b;

    vga_if vin ();
    vga_if vout_a ();
    vga_if vout_b ();
    pos_if pos ();

    draw_sprite #(.SPRITE_W(4), .SPRITE_H(2), .ADDR_W(3), .ROM_LAT(1), .TRANSP(12'hFFF),
                  .BLINK_FRAMES(16), .BLINK_LOG2(2)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .pin(pos), .enable(enable), .mirror(mirror),
        .blink_start(blink_start), .in(vin), .address(addr_a), .out(vout_a));

    draw_sprite #(.SPRITE_W(5), .SPRITE_H(3), .ADDR_W(4), .ROM_LAT(3), .TRANSP(12'h0F0),
                  .BLINK_FRAMES(5), .BLINK_LOG2(0)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .pin(pos), .enable(enable), .mirror(mirror),
        .blink_start(blink_start), .in(vin), .address(addr_b), .out(vout_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous sprite ROMs with 1 and 3 cycles of read latency.
    logic [11:0] rom_a [8];
    logic [11:0] rom_b [16];
    logic [11:0] rd_a, rd_b0, rd_b1, rd_b2;
    always @(posedge clk) begin
        rd_a  <= rom_a[addr_a];
        rd_b0 <= rom_b[addr_b];
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign data_a = rd_a;
    assign data_b = rd_b2;

    // Reference model parameters and state, one entry per instance.
    int          sw  [2] = '{4, 5};
    int          sh  [2] = '{2, 3};
    int          lat [2] = '{1, 3};
    int          aw  [2] = '{3, 4};
    int          bf  [2] = '{16, 5};
    int          bl  [2] = '{2, 0};
    logic [11:0] tr  [2] = '{12'hFFF, 12'h0F0};
    int          xl [2], yl [2], cnt [2], aprev [2];
    bit          enl [2], mirl [2], vis [2];

    logic [37:0] ex_out  [2][8];
    int          ex_addr [2][8];
    int          hh [8], hv [8];

    int n_cmp = 0, n_err = 0, cyc = 0;
    bit rst_prev = 1'b0;

    bit          dir_on = 1'b0;
    logic [11:0] e116, e105, e115;
    int          ea105, ea116;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        xl[d] = 0; yl[d] = 0; enl[d] = 0; mirl[d] = 0; cnt[d] = 0; vis[d] = 1; aprev[d] = 0;
    endtask

    task automatic model_step(input int d, input int s);
        int hc, vc, col, row, a;
        bit hit, fs;
        logic [11:0] word, px;
        hc = int'(vin.hcount);
        vc = int'(vin.vcount);
        fs = (hc == 0) && (vc == 0);
        hit = enl[d] && vis[d] && hc >= xl[d] && hc < xl[d] + sw[d] &&
              vc >= yl[d] && vc < yl[d] + sh[d];
        px = vin.rgb;
        if (hit) begin
            col = hc - xl[d];
            if (mirl[d]) col = sw[d] - 1 - col;
            row = vc - yl[d];
            a = (row * sw[d] + col) % (1 << aw[d]);
            word = (d == 0) ? rom_a[a] : rom_b[a];
            if (word != tr[d]) px = word;
            aprev[d] = a;
        end
        ex_out[d][s]  = {vin.vcount, vin.hcount, vin.vsync, vin.vblnk, vin.hsync, vin.hblnk, px};
        ex_addr[d][s] = aprev[d];
        if (fs) begin
            xl[d] = int'(pos.x); yl[d] = int'(pos.y); enl[d] = enable; mirl[d] = mirror;
        end
        if (blink_start) cnt[d] = bf[d];
        else if (fs && cnt[d] > 0) cnt[d] = cnt[d] - 1;
        if (fs) vis[d] = (cnt[d] == 0) || (((cnt[d] / (1 << bl[d])) % 2) == 0);
    endtask

    // One clock: check outputs at the falling edge, advance the model, return after next rise.
    task automatic cycle();
        logic [37:0] got;
        int gaddr, s, sp, sa;
        @(negedge clk);
        s = cyc % 8;
        hh[s] = int'(vin.hcount);
        hv[s] = int'(vin.vcount);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                got   = {vout_a.vcount, vout_a.hcount, vout_a.vsync, vout_a.vblnk,
                         vout_a.hsync, vout_a.hblnk, vout_a.rgb};
                gaddr = int'(addr_a);
            end else begin
                got   = {vout_b.vcount, vout_b.hcount, vout_b.vsync, vout_b.vblnk,
                         vout_b.hsync, vout_b.hblnk, vout_b.rgb};
                gaddr = int'(addr_b);
            end
            sp = (cyc + 8 - lat[d] - 2) % 8;
            sa = (cyc + 7) % 8;
            chk(d == 0 ? "out_a" : "out_b", 64'(got), 64'(ex_out[d][sp]));
            chk(d == 0 ? "addr_a" : "addr_b", 64'(gaddr), 64'(ex_addr[d][sa]));
            if (rst_prev) begin
                chk("rst_out_zero", 64'(got), 64'd0);
                chk("rst_addr_zero", 64'(gaddr), 64'd0);
            end
            if (dir_on && d == 0) begin
                if (hh[sp] == 11 && hv[sp] == 6) chk("px_11_6", 64'(got[11:0]), 64'(e116));
                if (hh[sp] == 10 && hv[sp] == 5) chk("px_10_5", 64'(got[11:0]), 64'(e105));
                if (hh[sp] == 11 && hv[sp] == 5) chk("px_11_5", 64'(got[11:0]), 64'(e115));
                if (hh[sp] == 14 && hv[sp] == 5) chk("px_14_5", 64'(got[11:0]), 64'h0A0);
                if (hh[sa] == 10 && hv[sa] == 5) chk("addr_10_5", 64'(gaddr), 64'(ea105));
                if (hh[sa] == 11 && hv[sa] == 6) chk("addr_11_6", 64'(gaddr), 64'(ea116));
            end
            if (rst) begin
                for (int k = 0; k < lat[d] + 2; k++) ex_out[d][(cyc + 8 - k) % 8] = '0;
                ex_addr[d][s] = 0;
                model_reset(d);
            end else begin
                model_step(d, s);
            end
        end
        rst_prev = rst;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit rnd_rgb, input int act, input int act_line);
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                vin.hcount  = 11'(h);
                vin.vcount  = 11'(v);
                vin.hblnk   = (h >= H_VIS);
                vin.hsync   = (h >= H_VIS + 2) && (h < H_VIS + 5);
                vin.vblnk   = (v >= V_VIS);
                vin.vsync   = (v == V_VIS + 1);
                vin.rgb     = rnd_rgb ? 12'($urandom) : 12'h0A0;
                blink_start = 1'b0;
                rst         = 1'b0;
                if (v == act_line && h == 20) begin
                    case (act)
                        1: begin pos.x = 11'd200; pos.y = 11'd100; end
                        2: mirror = ~mirror;
                        3: blink_start = 1'b1;
                        4: rst = 1'b1;
                        default: ;
                    endcase
                end
                cycle();
            end
        end
    endtask

    // Expected directed values for the 4x2 sprite at (10,5).
    task automatic set_dir(input bit drawn, input bit mir);
        if (!drawn) begin
            e116 = 12'h0A0; e105 = 12'h0A0; e115 = 12'h0A0; ea105 = 7; ea116 = 7;
        end else if (mir) begin
            e116 = 12'h106; e105 = 12'h103; e115 = 12'h102; ea105 = 3; ea116 = 6;
        end else begin
            e116 = 12'h105; e105 = 12'h0A0; e115 = 12'h123; ea105 = 0; ea116 = 5;
        end
    endtask

    function automatic bit drawn_at(input int k);
        return !((k >= 12 && k <= 15) || (k >= 4 && k <= 7));
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            for (int i = 0; i < 8; i++) begin ex_out[d][i] = '0; ex_addr[d][i] = 0; end
        end
        for (int i = 0; i < 8; i++) begin hh[i] = -1; hv[i] = -1; end
        for (int k = 0; k < 8; k++) rom_a[k] = 12'h100 + 12'(k);
        rom_a[0] = 12'hFFF;
        rom_a[1] = 12'h123;
        for (int k = 0; k < 16; k++) rom_b[k] = ($urandom_range(0, 3) == 0) ? 12'h0F0 : 12'($urandom);

        rst = 1'b1; enable = 1'b0; mirror = 1'b0; blink_start = 1'b0;
        pos.x = '0; pos.y = '0;
        vin.hcount = '0; vin.vcount = '0; vin.vsync = 0; vin.vblnk = 0;
        vin.hsync = 0; vin.hblnk = 0; vin.rgb = '0;
        @(posedge clk);
        #1;
        repeat (3) cycle();

        // Directed: plain, mirrored with mid-frame toggle, pin moved mid-frame, moved away.
        dir_on = 1'b1;
        pos.x = 11'd10; pos.y = 11'd5; enable = 1'b1; mirror = 1'b0;
        set_dir(1'b1, 1'b0); run_frame(1'b0, 0, 0);
        mirror = 1'b1;
        set_dir(1'b1, 1'b1); run_frame(1'b0, 2, 2);
        set_dir(1'b1, 1'b0); run_frame(1'b0, 1, 2);
        set_dir(1'b0, 1'b0); run_frame(1'b0, 0, 0);

        // Blink: pulse, re-pulse while counting at 9, then run down to zero.
        pos.x = 11'd10; pos.y = 11'd5;
        set_dir(1'b1, 1'b0); run_frame(1'b0, 3, 1);
        for (int k = 15; k >= 9; k--) begin
            set_dir(drawn_at(k), 1'b0);
            run_frame(1'b0, (k == 9) ? 3 : 0, 1);
        end
        for (int k = 15; k >= 0; k--) begin
            set_dir(drawn_at(k), 1'b0);
            run_frame(1'b0, 0, 0);
        end
        repeat (2) begin set_dir(1'b1, 1'b0); run_frame(1'b0, 0, 0); end

        // Reset pulse mid-line.
        dir_on = 1'b0;
        run_frame(1'b0, 4, 3);

        // Randomized frames.
        for (int k = 0; k < 8; k++) rom_a[k] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
        for (int k = 0; k < 16; k++) rom_b[k] = ($urandom_range(0, 3) == 0) ? 12'h0F0 : 12'($urandom);
        for (int f = 0; f < 12; f++) begin
            pos.x  = 11'($urandom_range(1, 40));
            pos.y  = 11'($urandom_range(1, 14));
            enable = ($urandom_range(0, 3) != 0);
            mirror = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: run_frame(1'b1, 0, 0);
                1: run_frame(1'b1, 2, $urandom_range(0, 15));
                2: run_frame(1'b1, 3, $urandom_range(0, 15));
                default: run_frame(1'b1, 1, $urandom_range(0, 15));
            endcase
        end

        // Clipping at the right/bottom edge of the 11-bit coordinate space.
        pos.x = 11'd2044; pos.y = 11'd2045; enable = 1'b1; mirror = 1'($urandom_range(0, 1));
        vin.hcount = '0; vin.vcount = '0; vin.rgb = 12'($urandom);
        vin.vsync = 0; vin.vblnk = 0; vin.hsync = 0; vin.hblnk = 0;
        blink_start = 1'b0; rst = 1'b0;
        cycle();
        repeat (400) begin
            vin.hcount = 11'($urandom_range(2030, 2047));
            vin.vcount = 11'($urandom_range(2035, 2047));
            vin.rgb    = 12'($urandom);
            vin.vsync  = 1'($urandom); vin.vblnk = 1'($urandom);
            vin.hsync  = 1'($urandom); vin.hblnk = 1'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
